// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds funct3 encodings, FSM state encoding, base byte masks, the response
// payload struct and small decode helpers used by the top and align block.
// Optional feature macro: YSYX_23060201_LSU_MISALIGN_CHK_EN.
package ysyx_23060201_lsu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned MEM_MASK_W = 8;

    // RV32 load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // RV32 store funct3
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Base byte-enable masks before lane shifting
    localparam logic [BE_W-1:0] BASE_MASK_B = 4'b0001;
    localparam logic [BE_W-1:0] BASE_MASK_H = 4'b0011;
    localparam logic [BE_W-1:0] BASE_MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    // funct3 legality: stores only allow B/H/W, loads also allow BU/HU
    function automatic logic f3_legal(input logic wen, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW: ok = 1'b1;
            F3_LBU, F3_LHU:      ok = ~wen;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Misalignment for the access size encoded in funct3[1:0]
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte offset rounded down to the natural alignment of the access size
    function automatic logic [1:0] natural_off(input logic [2:0] f3, input logic [1:0] lo);
        logic [1:0] off;
        case (f3[1:0])
            2'b00:   off = lo;
            2'b01:   off = {lo[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Combinational lane alignment for the LSU.
// Ports: funct3_i (access type), off_i (byte offset in word), raw_i (memory
// read word), wdata_i (LSB-aligned store data) -> mask_o (byte enables),
// wdata_o (lane-shifted store data), rdata_o (shifted and extended load data).
module ysyx_23060201_lsu_align
    import ysyx_23060201_lsu_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        off_i,
    input  logic [DATA_W-1:0] raw_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [BE_W-1:0]   mask_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [4:0]        shamt;
    logic [BE_W-1:0]   base_mask;
    logic [DATA_W-1:0] shifted;

    assign shamt = {off_i, 3'b000};

    // Mask, store lane shift and load extension
    always_comb begin
        case (funct3_i[1:0])
            2'b01:   base_mask = BASE_MASK_H;
            2'b10:   base_mask = BASE_MASK_W;
            default: base_mask = BASE_MASK_B;
        endcase
        mask_o  = base_mask << off_i;
        wdata_o = wdata_i << shamt;
        shifted = raw_i >> shamt;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata_o = {24'd0, shifted[7:0]};
            F3_LHU:  rdata_o = {16'd0, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit in front of the data memory; one outstanding access.
// Ports: clk, rst_n (sync, active-low); EXU request req_valid/req_ready with
// req_wen, req_funct3, req_addr, req_wdata; WBU response rsp_valid/rsp_ready
// with rsp_rdata, rsp_err; memory side mem_ren/mem_raddr/mem_rmask/mem_rdata
// and mem_wen/mem_waddr/mem_wmask/mem_wdata.
// Macro YSYX_23060201_LSU_MISALIGN_CHK_EN: when defined, misaligned accesses
// return rsp_err without touching memory; otherwise the offset is rounded to
// natural alignment and the access proceeds.
module ysyx_23060201_lsu
    import ysyx_23060201_lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32   // only 32 supported
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [MEM_MASK_W-1:0] mem_rmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [MEM_MASK_W-1:0] mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    state_e                state_q, state_d;
    logic                  wen_q, wen_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    rsp_t                  rsp_q, rsp_d;

    logic                  can_accept;
    logic                  req_fire;
    logic                  req_legal;
    logic                  rd_en, wr_en;
    logic [1:0]            off;
    logic [BE_W-1:0]       lane_mask;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] ext_rdata;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign can_accept = (state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready);
    assign req_ready  = can_accept;
    assign req_fire   = req_valid & can_accept;

`ifdef YSYX_23060201_LSU_MISALIGN_CHK_EN
    assign req_legal = f3_legal(req_wen, req_funct3) & ~misaligned(req_funct3, req_addr[1:0]);
    assign off       = addr_q[1:0];
`else
    assign req_legal = f3_legal(req_wen, req_funct3);
    assign off       = natural_off(funct3_q, addr_q[1:0]);
`endif

    // Enables gated by rst_n so a reset edge during ACCESS never writes
    assign rd_en     = (state_q == ST_ACCESS) & rst_n & ~wen_q;
    assign wr_en     = (state_q == ST_ACCESS) & rst_n & wen_q;
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    ysyx_23060201_lsu_align u_align (
        .funct3_i (funct3_q),
        .off_i    (off),
        .raw_i    (mem_rdata),
        .wdata_i  (wdata_q),
        .mask_o   (lane_mask),
        .wdata_o  (lane_wdata),
        .rdata_o  (ext_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (req_fire)                                state_d = req_legal ? ST_ACCESS : ST_RESP;
                else if ((state_q == ST_RESP) && rsp_ready) state_d = ST_IDLE;
            end
            ST_ACCESS: state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and request/response register next values
    always_comb begin
        wen_d       = wen_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;

        mem_ren   = rd_en;
        mem_wen   = wr_en;
        mem_raddr = rd_en ? word_addr : '0;
        mem_rmask = rd_en ? {4'b0000, lane_mask} : '0;
        mem_waddr = wr_en ? word_addr : '0;
        mem_wmask = wr_en ? {4'b0000, lane_mask} : '0;
        mem_wdata = wr_en ? lane_wdata : '0;

        // Response consumed
        if ((state_q == ST_RESP) && rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_d       = '0;
        end

        // Capture new request; illegal ones answer immediately with an error
        if (req_fire) begin
            wen_d    = req_wen;
            funct3_d = req_funct3;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            if (!req_legal) begin
                rsp_valid_d = 1'b1;
                rsp_d.err   = 1'b1;
                rsp_d.rdata = '0;
            end
        end

        // Memory data sampled on the ACCESS->RESP edge
        if (state_q == ST_ACCESS) begin
            rsp_valid_d = 1'b1;
            rsp_d.err   = 1'b0;
            rsp_d.rdata = wen_q ? '0 : ext_rdata;
        end
    end

    // Request and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_q       <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            wen_q       <= wen_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_q.err;
    assign rsp_rdata = rsp_q.rdata;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Self-checking bench for ysyx_23060201_lsu: directed vector table, hand-written
// stall/back-to-back and reset-during-access sequences, and random traffic
// against a byte-level memory reference model.
module tb_ysyx_23060201_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_raddr, mem_waddr, mem_rdata, mem_wdata;
    logic [7:0]  mem_rmask, mem_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060201_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata)
    );

    // Bench-side data memory: 16 words at 0x80000000
    logic [31:0] dmem [16];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) dmem[pl_idx] <= pl_data;
        else if (mem_wen)
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) dmem[mem_waddr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    assign mem_rdata = mem_ren ? dmem[mem_raddr[5:2]] : 32'hDEAD0000;

    logic [31:0] ref_mem [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[idx] = data;
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit f3_ok(input bit wen, input logic [2:0] f3);
        if (wen) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    // Reference: expected access and result from the architectural rules
    task automatic model(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output bit e_err, output int e_off,
                         output logic [31:0] e_addr, output logic [3:0] e_mask,
                         output logic [31:0] e_wd, output logic [31:0] e_rd);
        int n;
        int off;
        logic [31:0] word, v;
        n   = nbytes(f3);
        off = int'(addr[1:0]);
        e_err = !f3_ok(wen, f3);
`ifdef YSYX_23060201_LSU_MISALIGN_CHK_EN
        if ((off % n) != 0) e_err = 1'b1;
`else
        off = off - (off % n);
`endif
        e_off  = off;
        e_addr = addr & 32'hFFFF_FFFC;
        e_mask = 4'(((32'd1 << n) - 32'd1) << off);
        e_wd   = wd << (8 * off);
        word   = ref_mem[addr[5:2]];
        v      = 32'd0;
        for (int k = 0; k < n; k++)
            if (!e_err && (off + k) < 4) v = v | (32'(word[8*(off+k) +: 8]) << (8 * k));
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        e_rd = (wen || e_err) ? 32'd0 : v;
    endtask

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int off);
        for (int k = 0; k < nbytes(f3); k++)
            ref_mem[addr[5:2]][8*(off+k) +: 8] = wd[8*k +: 8];
    endtask

    // One request through handshake, access, optional stall, and consume
    task automatic do_txn(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold, input bit e_err,
                          input logic [31:0] e_addr, input logic [3:0] e_mask,
                          input logic [31:0] e_wd, input logic [31:0] e_rd, input int off);
        logic [31:0] held;
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        rsp_ready = 1'b1;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (e_err) begin
            chk("err_no_access", 32'({mem_ren, mem_wen}), 32'd0);
        end else begin
            chk("access_en", 32'({mem_ren, mem_wen}), wen ? 32'd1 : 32'd2);
            chk("access_no_rsp", 32'(rsp_valid), 32'd0);
            if (wen) begin
                chk("waddr", mem_waddr, e_addr);
                chk("wmask", 32'(mem_wmask), 32'(e_mask));
                chk("wdata", mem_wdata, e_wd);
            end else begin
                chk("raddr", mem_raddr, e_addr);
                chk("rmask", 32'(mem_rmask), 32'(e_mask));
            end
            @(posedge clk); #1;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("resp_no_en", 32'({mem_ren, mem_wen}), 32'd0);
        held = rsp_rdata;
        if (hold > 0) begin
            rsp_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_rdata", rsp_rdata, held);
                chk("hold_err", 32'(rsp_err), 32'(e_err));
                chk("hold_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("rsp_consumed", 32'(rsp_valid), 32'd0);
        if (wen && !e_err) ref_store(f3, addr, wd, off);
    endtask

    typedef struct {
        bit          wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          pre;
        logic [31:0] pre_val;
        bit          e_err;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs[$];
        bit   m_err;
        int   m_off;
        logic [31:0] m_addr, m_wd, m_rd, a, wd;
        logic [3:0]  m_mask;
        logic [2:0]  f3;
        bit          wen;

        vecs.push_back('{1'b1, 3'd2, 32'h80000004, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h80000004, 4'hF, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 3'd0, 32'h80000007, 32'h0, 1'b1, 32'h80FF1234, 1'b0, 32'h80000004, 4'h8, 32'h0, 32'hFFFFFF80});
        vecs.push_back('{1'b0, 3'd4, 32'h80000007, 32'h0, 1'b1, 32'h80FF1234, 1'b0, 32'h80000004, 4'h8, 32'h0, 32'h00000080});
        vecs.push_back('{1'b1, 3'd1, 32'h80000002, 32'h0000ABCD, 1'b0, 32'h0, 1'b0, 32'h80000000, 4'hC, 32'hABCD0000, 32'h0});
        vecs.push_back('{1'b0, 3'd1, 32'h80000002, 32'h0, 1'b1, 32'hABCD0000, 1'b0, 32'h80000000, 4'hC, 32'h0, 32'hFFFFABCD});
        vecs.push_back('{1'b0, 3'd3, 32'h80000008, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 3'd4, 32'h80000008, 32'h55, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd5, 32'h8000000A, 32'h0, 1'b1, 32'hF00D8001, 1'b0, 32'h80000008, 4'hC, 32'h0, 32'h0000F00D});
        vecs.push_back('{1'b1, 3'd0, 32'h80000009, 32'h123456A5, 1'b0, 32'h0, 1'b0, 32'h80000008, 4'h2, 32'h3456A500, 32'h0});
`ifdef YSYX_23060201_LSU_MISALIGN_CHK_EN
        vecs.push_back('{1'b0, 3'd2, 32'h80000002, 32'h0, 1'b1, 32'h12345678, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd1, 32'h80000011, 32'h0, 1'b1, 32'h00008001, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 3'd2, 32'h8000000E, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
`else
        vecs.push_back('{1'b0, 3'd2, 32'h80000002, 32'h0, 1'b1, 32'h12345678, 1'b0, 32'h80000000, 4'hF, 32'h0, 32'h12345678});
        vecs.push_back('{1'b0, 3'd1, 32'h80000011, 32'h0, 1'b1, 32'h00008001, 1'b0, 32'h80000010, 4'h3, 32'h0, 32'hFFFF8001});
        vecs.push_back('{1'b1, 3'd2, 32'h8000000E, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 32'h8000000C, 4'hF, 32'hCAFEF00D, 32'h0});
`endif

        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        pl_en = 1'b0; pl_idx = 4'd0; pl_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_en", 32'({mem_ren, mem_wen}), 32'd0);
        chk("rst_masks", 32'({mem_rmask, mem_wmask}), 32'd0);
        chk("rst_addrs", mem_raddr | mem_waddr | mem_wdata, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) preload(4'(i), $urandom);

        // Directed vector table
        foreach (vecs[i]) begin
            if (vecs[i].pre) preload(vecs[i].addr[5:2], vecs[i].pre_val);
            model(vecs[i].wen, vecs[i].f3, vecs[i].addr, vecs[i].wd, m_err, m_off, m_addr, m_mask, m_wd, m_rd);
            do_txn(vecs[i].wen, vecs[i].f3, vecs[i].addr, vecs[i].wd, 0, vecs[i].e_err,
                   vecs[i].e_addr, vecs[i].e_mask, vecs[i].e_wd, vecs[i].e_rd, m_off);
        end

        // Stall 3 cycles with a pending request, then back-to-back accept
        preload(4'd8, 32'h0BADF00D);
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80000020;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk("b2b_ren", 32'(mem_ren), 32'd1);
        @(posedge clk); #1;
        chk("b2b_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata", rsp_rdata, 32'h0BADF00D);
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd0; req_addr = 32'h80000021; req_wdata = 32'h00000077;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, 32'h0BADF00D);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_no_en", 32'({mem_ren, mem_wen}), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_wen", 32'(mem_wen), 32'd1);
        chk("b2b_wmask", 32'(mem_wmask), 32'h02);
        chk("b2b_wdata", mem_wdata, 32'h00007700);
        chk("b2b_rsp_gone", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("b2b_rsp2", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata2", rsp_rdata, 32'd0);
        ref_mem[8][15:8] = 8'h77;
        @(posedge clk); #1;
        chk("b2b_done", 32'(rsp_valid), 32'd0);

        // Reset asserted during a store ACCESS cycle
        preload(4'd3, 32'h11112222);
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd2; req_addr = 32'h8000000C; req_wdata = 32'h99999999;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_acc_wen_pre", 32'(mem_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_acc_wen", 32'(mem_wen), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b0;
        chk("rst_acc_valid", 32'(rsp_valid), 32'd0);
        chk("rst_acc_mem", dmem[3], ref_mem[3]);
        #1;
        chk("rst_acc_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("rst_acc_dropped", 32'(rsp_valid), 32'd0);
        chk("rst_acc_no_en", 32'({mem_ren, mem_wen}), 32'd0);

        // Random traffic against the reference model
        for (int i = 0; i < 200; i++) begin
            wen = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = 32'h80000000 | 32'($urandom_range(0, 63));
            wd  = $urandom;
            model(wen, f3, a, wd, m_err, m_off, m_addr, m_mask, m_wd, m_rd);
            do_txn(wen, f3, a, wd, $urandom_range(0, 2), m_err, m_addr, m_mask, m_wd, m_rd, m_off);
        end
        for (int i = 0; i < 16; i++) chk("final_mem", dmem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060201_lsu.md
Name: ysyx_23060201_lsu

Overview:
- Load/store unit directly upstream of the DPI-backed data memory.
- Accepts one load/store request from EXU via valid/ready and drives the memory's mem_ren/raddr/rmask and mem_wen/waddr/wmask/wdata.
- Samples mem_rdata, shifts and extends it, and returns a response to WBU via valid/ready.
- Multi-cycle FSM, one outstanding access.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; only 32 supported.

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  EXU request valid
- req_ready  out  1  LSU can accept a request
- req_wen  in  1  1=store, 0=load
- req_funct3  in  3  RV32 load/store funct3
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, LSB-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  WBU accepts response
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3
- mem_ren  out  1  memory read enable
- mem_raddr  out  ADDR_WIDTH  word-aligned read address
- mem_rmask  out  8  byte enables; bits [7:4] always 0
- mem_rdata  in  DATA_WIDTH  memory read data, valid while mem_ren=1
- mem_wen  out  1  memory write enable; memory writes on posedge
- mem_waddr  out  ADDR_WIDTH  word-aligned write address
- mem_wmask  out  8  byte enables; bits [7:4] always 0
- mem_wdata  out  DATA_WIDTH  lane-shifted store data

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, request registers=0.
- Outputs in reset: mem_ren=0, mem_wen=0, masks=0, addresses/wdata=0.
- States:
  - IDLE → ACCESS on req_valid & req_ready when the request is legal.
  - IDLE → RESP with err=1 when the request is illegal; no memory access.
  - ACCESS → RESP unconditionally after 1 cycle.
  - RESP → IDLE on rsp_ready & !req_valid.
  - RESP → ACCESS (or RESP for an illegal request) on rsp_ready & req_valid.
  - RESP holds while rsp_ready=0.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready).
- Request captured into registers on handshake. Memory outputs are driven from registers only.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: funct3 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Misaligned (illegal):
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
- In ACCESS:
  - address = {addr[ADDR_WIDTH-1:2], 2'b00}; off = addr[1:0]
  - base mask: B=4'b0001, H=4'b0011, W=4'b1111
  - mask = base << off
  - mem_wdata = req_wdata << (8*off)
- mem_ren = (state==ACCESS) & !wen.
- mem_wen = (state==ACCESS) & wen & rst_n, so no write happens on a reset edge.
- Both enables are 0 in all other states.
- Load data:
  - mem_rdata sampled at the ACCESS→RESP edge, shifted right by 8*off.
  - LB/LH: sign-extended from bit 7/15.
  - LBU/LHU: zero-extended.
  - LW: passed through.
- Latency: handshake at edge N → ACCESS in cycle N+1 → rsp_valid=1 from edge N+2. Error path: rsp_valid from edge N+1.
- rsp_rdata and rsp_err stay stable while rsp_valid & !rsp_ready.
- Reset mid-ACCESS: no write, rsp_valid=0 after the edge, and the request is dropped.

Optional Feature:
- Macro: YSYX_23060201_LSU_MISALIGN_CHK_EN.
- Defined: misaligned accesses produce rsp_err=1 with no memory access, as specified above.
- Undefined:
  - misalignment is not checked.
  - off is forced to the natural alignment: H uses {addr[1],1'b0}, W uses 2'b00.
  - the access proceeds.
  - rsp_err is set only for illegal funct3.

Decomposition:
- defines.v holds:
  - funct3 constants (LB..LHU, SB..SW)
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - base-mask constants
- Sub-module ysyx_23060201_lsu_align (combinational):
  - inputs funct3, off, raw word, store data
  - outputs byte mask, shifted wdata, extended rdata

Test Plan:
1. SW addr=0x80000004 wdata=0xDEADBEEF → ACCESS cycle: mem_wen=1, waddr=0x80000004, wmask=0x0F, wdata=0xDEADBEEF; rsp_valid=1, rsp_err=0 two cycles after handshake.
2. LB addr=0x80000007 with mem_rdata=0x80FF1234 → rmask=0x08, raddr=0x80000004, rsp_rdata=0xFFFFFF80. Same access as LBU → 0x00000080.
3. SH addr=0x80000002 wdata=0x0000ABCD → wmask=0x0C, wdata=0xABCD0000. LH at the same address with mem_rdata=0xABCD0000 → 0xFFFFABCD.
4. LW addr=0x80000002, macro defined → no mem_ren, rsp_err=1, rsp_rdata=0 one cycle after handshake. Macro undefined → raddr=0x80000000, rmask=0x0F, rsp_err=0.
5. rsp_ready=0 for 3 cycles after a load → rsp_valid and rsp_rdata held, req_ready=0. Then rsp_ready=1 with req_valid=1 → back-to-back accept, next ACCESS on the following cycle.
6. rst_n=0 asserted during an SW ACCESS cycle → mem_wen=0 that cycle, no pmem write, state=IDLE, rsp_valid=0 after the edge.
